// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader: FSM state
// encodings, frame byte-order constants and the checksum step helper.
package imem_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Words are sent least significant byte first: lane 0 is bits [7:0].
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LANE_FIRST     = 2'd0;
    localparam logic [1:0] LANE_LAST      = 2'd3;

    // One step of the frame checksum: plain XOR of every data byte.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_stream_loader_word_packer.sv
// Byte-to-word packer: places each data byte in its lane, raises a one-cycle
// write strobe with the assembled word after the last lane, and keeps the
// running XOR checksum of all data bytes since the last clear.
module imem_word_packer
    import imem_stream_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_data,
    output logic        word_we,
    output logic [31:0] word_data,
    output logic [7:0]  csum
);

    logic [23:0] lanes_r;
    logic        we_r;
    logic [31:0] data_r;
    logic [7:0]  csum_r;

    // Lane assembly, one-cycle word strobe and checksum accumulation
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lanes_r <= 24'd0;
            we_r    <= 1'b0;
            data_r  <= 32'd0;
            csum_r  <= 8'd0;
        end else if (clear) begin
            lanes_r <= 24'd0;
            we_r    <= 1'b0;
            csum_r  <= 8'd0;
        end else if (byte_en) begin
            csum_r <= csum_step(csum_r, byte_data);
            we_r   <= 1'b0;
            case (lane)
                2'd0:    lanes_r[7:0]   <= byte_data;
                2'd1:    lanes_r[15:8]  <= byte_data;
                2'd2:    lanes_r[23:16] <= byte_data;
                2'd3: begin
                    data_r <= {byte_data, lanes_r};
                    we_r   <= 1'b1;
                end
                default: lanes_r <= lanes_r;
            endcase
        end else begin
            we_r <= 1'b0;
        end
    end

    assign word_we   = we_r;
    assign word_data = data_r;
    assign csum      = csum_r;

endmodule

// File: rtl/imem_stream_loader.sv
// Instruction-memory loader: receives a length-prefixed, XOR-checksummed byte
// frame, writes it word by word into instruction memory and releases the
// core reset only once a complete frame with a good checksum has landed.
module imem_stream_loader
    import imem_stream_loader_pkg::*;
#(
    parameter int PC_SIZE       = 32,
    parameter int INST_MEM_SIZE = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [PC_SIZE-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error
);

    localparam logic [15:0] MAX_WORDS = 16'(INST_MEM_SIZE / BYTES_PER_WORD);

    state_t             state_r, next_state_s;
    logic               xfer_s, arm_s, last_byte_s;
    logic [15:0]        len_full_s;
    logic [7:0]         len_lo_r;
    logic [15:0]        len_r, word_idx_r;
    logic [1:0]         lane_r;
    logic [PC_SIZE-1:0] imem_addr_r;
    logic [7:0]         csum_s;
    logic               rx_ready_s, core_reset_s, load_done_s, load_error_s;
    logic               rx_ready_r, core_reset_r, load_done_r, load_error_r;

    assign xfer_s      = rx_valid & rx_ready_r;
    assign arm_s       = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERROR));
    assign len_full_s  = {rx_data, len_lo_r};
    assign last_byte_s = (lane_r == LANE_LAST) && (word_idx_r == (len_r - 16'd1));

    imem_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (arm_s),
        .byte_en   (xfer_s & (state_r == ST_DATA)),
        .lane      (lane_r),
        .byte_data (rx_data),
        .word_we   (imem_we),
        .word_data (imem_wdata),
        .csum      (csum_s)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode for the frame parser
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (arm_s) next_state_s = ST_LEN_LO;
                else       next_state_s = state_r;
            end
            ST_LEN_LO: begin
                if (xfer_s) next_state_s = ST_LEN_HI;
                else        next_state_s = state_r;
            end
            ST_LEN_HI: begin
                if (!xfer_s)                      next_state_s = state_r;
                else if (len_full_s == 16'd0)     next_state_s = ST_CSUM;
                else if (len_full_s > MAX_WORDS)  next_state_s = ST_ERROR;
                else                              next_state_s = ST_DATA;
            end
            ST_DATA: begin
                if (xfer_s && last_byte_s) next_state_s = ST_CSUM;
                else                       next_state_s = state_r;
            end
            ST_CSUM: begin
                if (!xfer_s)                next_state_s = state_r;
                else if (rx_data == csum_s) next_state_s = ST_DONE;
                else                        next_state_s = ST_ERROR;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flopped outputs track it
    always_comb begin
        rx_ready_s   = 1'b0;
        core_reset_s = 1'b0;
        load_done_s  = 1'b0;
        load_error_s = 1'b0;
        case (next_state_s)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: rx_ready_s = 1'b1;
            ST_DONE: begin
                core_reset_s = 1'b1;
                load_done_s  = 1'b1;
            end
            ST_ERROR: load_error_s = 1'b1;
            default:  rx_ready_s   = 1'b0;
        endcase
    end

    // Registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_ready_r   <= 1'b0;
            core_reset_r <= 1'b0;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            rx_ready_r   <= rx_ready_s;
            core_reset_r <= core_reset_s;
            load_done_r  <= load_done_s;
            load_error_r <= load_error_s;
        end
    end

    // Length capture, byte lane / word counters and write address
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_lo_r    <= 8'd0;
            len_r       <= 16'd0;
            word_idx_r  <= 16'd0;
            lane_r      <= LANE_FIRST;
            imem_addr_r <= '0;
        end else if (arm_s) begin
            len_lo_r   <= 8'd0;
            len_r      <= 16'd0;
            word_idx_r <= 16'd0;
            lane_r     <= LANE_FIRST;
        end else if (xfer_s) begin
            case (state_r)
                ST_LEN_LO: len_lo_r <= rx_data;
                ST_LEN_HI: len_r    <= len_full_s;
                ST_DATA: begin
                    lane_r <= lane_r + 2'd1;
                    if (lane_r == LANE_LAST) begin
                        word_idx_r  <= word_idx_r + 16'd1;
                        imem_addr_r <= PC_SIZE'({word_idx_r, 2'b00});
                    end
                end
                default: len_r <= len_r;
            endcase
        end
    end

    assign rx_ready   = rx_ready_r;
    assign core_reset = core_reset_r;
    assign load_done  = load_done_r;
    assign load_error = load_error_r;
    assign imem_addr  = imem_addr_r;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed self-checking bench for imem_stream_loader.
module tb_imem_stream_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, imem_we, core_reset, load_done, load_error;
    logic [31:0] imem_addr, imem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         wr_q[$];
    int          hs_q[$];
    logic [31:0] wbuf [0:299];

    imem_stream_loader #(.PC_SIZE(32), .INST_MEM_SIZE(1024)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    // Write monitor, sampled mid-cycle
    always @(negedge clock) begin
        wr_t w;
        cyc = cyc + 1;
        if (imem_we) begin
            w.addr = imem_addr;
            w.data = imem_wdata;
            w.cyc  = cyc;
            wr_q.push_back(w);
        end
    end

    function automatic logic [7:0] model_csum(input int n);
        logic [7:0] acc = 8'h00;
        for (int i = 0; i < n; i++)
            acc = acc ^ wbuf[i][7:0] ^ wbuf[i][15:8] ^ wbuf[i][23:16] ^ wbuf[i][31:24];
        return acc;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            rx_valid = 1'b0;
        end
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_ready_timeout: rx_ready=%0b required 1", rx_ready);
        end
        @(posedge clock);
        hs_q.push_back(cyc);
    endtask

    task automatic idle();
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] n, input int nsend, input bit send_cs,
                              input logic [7:0] cs, input int maxgap, input int mid_start);
        int idx;
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        for (int i = 0; i < nsend; i++) begin
            for (int k = 0; k < 4; k++) begin
                idx = i * 4 + k;
                if (idx == mid_start) begin
                    @(negedge clock);
                    rx_valid = 1'b0;
                    start    = 1'b1;
                    @(negedge clock);
                    start    = 1'b0;
                end
                send_byte(wbuf[i][k*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            end
        end
        if (send_cs) send_byte(cs, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        idle();
    endtask

    task automatic check_two_writes(input string tag);
        if (wr_q.size() !== 2) begin
            n_fail++;
            $display("FAIL %s_wr_count: got %0d required 2", tag, wr_q.size());
        end else begin
            if ({wr_q[0].addr, wr_q[0].data} !== {32'h0000_0000, 32'h0050_0093}) begin
                n_fail++;
                $display("FAIL %s_wr0: got %h/%h required 00000000/00500093", tag, wr_q[0].addr, wr_q[0].data);
            end
            n_checks++;
            if ({wr_q[1].addr, wr_q[1].data} !== {32'h0000_0004, 32'h00A0_0113}) begin
                n_fail++;
                $display("FAIL %s_wr1: got %h/%h required 00000004/00a00113", tag, wr_q[1].addr, wr_q[1].data);
            end
            n_checks++;
        end
        n_checks++;
    endtask

    task automatic test_reset();
        #2;
        if ({rx_ready, imem_we, core_reset, load_done, load_error} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {rx_ready, imem_we, core_reset, load_done, load_error});
        end
        n_checks++;
        if ({imem_addr, imem_wdata} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%h required 0/0", imem_addr, imem_wdata);
        end
        n_checks++;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_good_frame();
        wbuf[0] = 32'h0050_0093;
        wbuf[1] = 32'h00A0_0113;
        wr_q.delete();
        hs_q.delete();
        pulse_start();
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL good_armed: rx_ready=%b required 1", rx_ready);
        end
        n_checks++;
        // bytes 93 00 50 00 13 01 a0 00 xor to 8'h71
        send_frame(16'd2, 2, 1'b1, 8'h71, 0, -1);
        if ({core_reset, load_done, load_error, rx_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL good_status: got %b required 1100", {core_reset, load_done, load_error, rx_ready});
        end
        n_checks++;
        repeat (2) @(negedge clock);
        check_two_writes("good");
        if (wr_q.size() == 2 && hs_q.size() >= 6) begin
            if (wr_q[0].cyc !== hs_q[5] + 1) begin
                n_fail++;
                $display("FAIL good_latency: write at %0d required %0d", wr_q[0].cyc, hs_q[5] + 1);
            end
            n_checks++;
            if (wr_q[1].cyc - wr_q[0].cyc !== 4) begin
                n_fail++;
                $display("FAIL good_spacing: got %0d required 4", wr_q[1].cyc - wr_q[0].cyc);
            end
            n_checks++;
        end
    endtask

    task automatic test_bad_csum();
        wr_q.delete();
        pulse_start();
        if ({core_reset, load_done, rx_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rearm_status: got %b required 001", {core_reset, load_done, rx_ready});
        end
        n_checks++;
        send_frame(16'd2, 2, 1'b1, 8'h00, 0, -1);
        repeat (3) @(negedge clock);
        if ({load_error, core_reset, load_done, rx_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL badcs_status: got %b required 1000", {load_error, core_reset, load_done, rx_ready});
        end
        n_checks++;
        check_two_writes("badcs");
    endtask

    task automatic test_overflow();
        wr_q.delete();
        pulse_start();
        if (load_error !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_err_clear: load_error=%b required 0", load_error);
        end
        n_checks++;
        send_frame(16'd257, 0, 1'b0, 8'h00, 0, -1);
        if ({load_error, rx_ready, core_reset} !== 3'b100) begin
            n_fail++;
            $display("FAIL ovf_status: got %b required 100", {load_error, rx_ready, core_reset});
        end
        n_checks++;
        repeat (4) @(negedge clock);
        if (wr_q.size() !== 0) begin
            n_fail++;
            $display("FAIL ovf_writes: got %0d required 0", wr_q.size());
        end
        n_checks++;
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 256; i++)
            wbuf[i] = {8'(i) ^ 8'h5A, 8'(i), ~8'(i), 8'h3C + 8'(i)};
        wr_q.delete();
        pulse_start();
        send_frame(16'd256, 256, 1'b1, model_csum(256), 0, -1);
        repeat (2) @(negedge clock);
        if (load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL max_done: load_done=%b required 1", load_done);
        end
        n_checks++;
        if (wr_q.size() !== 256) begin
            n_fail++;
            $display("FAIL max_count: got %0d required 256", wr_q.size());
        end else if ({wr_q[255].addr, wr_q[255].data} !== {32'h0000_03FC, wbuf[255]}) begin
            n_fail++;
            $display("FAIL max_last: got %h/%h required 000003fc/%h", wr_q[255].addr, wr_q[255].data, wbuf[255]);
        end
        n_checks++;
    endtask

    task automatic test_zero_len();
        wr_q.delete();
        pulse_start();
        send_frame(16'd0, 0, 1'b1, 8'h00, 0, -1);
        repeat (2) @(negedge clock);
        if ({load_done, core_reset, load_error} !== 3'b110 || wr_q.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_len: status %b writes %0d required 110 and 0",
                     {load_done, core_reset, load_error}, wr_q.size());
        end
        n_checks++;
    endtask

    task automatic test_gaps();
        wbuf[0] = 32'h0050_0093;
        wbuf[1] = 32'h00A0_0113;
        wr_q.delete();
        pulse_start();
        send_frame(16'd2, 2, 1'b1, 8'h71, 3, -1);
        repeat (2) @(negedge clock);
        if (load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_done: load_done=%b required 1", load_done);
        end
        n_checks++;
        check_two_writes("gaps");
    endtask

    task automatic test_reset_mid();
        wr_q.delete();
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        for (int k = 0; k < 6; k++) send_byte(wbuf[k / 4][(k % 4)*8 +: 8], 0);
        @(negedge clock);
        rx_valid = 1'b0;
        reset    = 1'b0;
        #1;
        if ({rx_ready, core_reset, load_done, load_error, imem_we} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_status: got %b required 00000", {rx_ready, core_reset, load_done, load_error, imem_we});
        end
        n_checks++;
        if (wr_q.size() !== 1) begin
            n_fail++;
            $display("FAIL midrst_writes: got %0d required 1", wr_q.size());
        end
        n_checks++;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: rx_ready=%b required 0", rx_ready);
        end
        n_checks++;
        wr_q.delete();
        pulse_start();
        send_frame(16'd2, 2, 1'b1, 8'h71, 0, 3);
        repeat (2) @(negedge clock);
        if ({load_done, core_reset, load_error} !== 3'b110) begin
            n_fail++;
            $display("FAIL reload_status: got %b required 110", {load_done, core_reset, load_error});
        end
        n_checks++;
        check_two_writes("reload");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_overflow();
        test_max_len();
        test_zero_len();
        test_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
